// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-lite core.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the
// per-state datapath strobes. All outputs are combinational from state, op,
// zero, stall and mem_ready; op is only looked at from DECODE onward.
// Optional feature macro: MC_CTRL_BNE_EN (makes opcode 000101 = BNE legal).
//
// Memory handshake: mem_req is held high in FETCH/MEM until a one-cycle
// mem_ready pulse completes the access; a mem_ready seen while stall=1 or
// outside FETCH/MEM is ignored; a completion and a timeout in the same cycle
// resolve as a normal completion.
module multicycle_ctrl #(
   parameter int ALU_OP_W    = 3,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          op,
   input  logic                zero,
   input  logic                stall,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_src,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                ext_op,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_we,
   output logic [1:0]          reg_dst,
   output logic [1:0]          wb_sel,
   output logic                illegal,
   output logic                bus_err,
   output logic [2:0]          state_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Counter wide enough to hold TIMEOUT_CYC; a limit of 0 never increments.
   localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
   logic             mem_phase;
   logic             timeout;

   function automatic logic op_known(input logic [5:0] o);
      case (o)
         OP_RTYPE, OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI,
         OP_ORI, OP_XORI, OP_LW, OP_SW: op_known = 1'b1;
`ifdef MC_CTRL_BNE_EN
         OP_BNE:                        op_known = 1'b1;
`endif
         default:                       op_known = 1'b0;
      endcase
   endfunction

   assign mem_phase = (state == S_FETCH) || (state == S_MEM);
   assign timeout   = (TIMEOUT_CYC != 0) && mem_phase && !stall && !mem_ready
                      && (to_cnt == TO_LIMIT);
   assign state_o   = state;

   // Next-state and datapath strobes for the current state; stall masks last.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      ext_op    = 1'b0;
      alu_op    = '0;
      reg_we    = 1'b0;
      reg_dst   = 2'd0;
      wb_sel    = 2'd0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (timeout) begin
               mem_req   = 1'b0;
               bus_err   = 1'b1;
               state_nxt = S_FETCH;
            end else if (mem_ready) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            ext_op    = 1'b1;
            if (op_known(op)) begin
               state_nxt = S_EXEC;
            end else begin
               illegal   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            case (op)
               OP_RTYPE: begin
                  alu_src_a = 1'b1;
                  alu_op    = ALU_OP_W'(3'b011);
                  state_nxt = S_WB;
               end
               OP_ORI, OP_XORI, OP_ANDI, OP_ADDI: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  ext_op    = (op == OP_ADDI);
                  case (op)
                     OP_ORI:  alu_op = ALU_OP_W'(3'b010);
                     OP_XORI: alu_op = ALU_OP_W'(3'b100);
                     OP_ANDI: alu_op = ALU_OP_W'(3'b101);
                     default: alu_op = ALU_OP_W'(3'b110);
                  endcase
                  state_nxt = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  ext_op    = 1'b1;
                  state_nxt = S_MEM;
               end
               OP_BEQ: begin
                  alu_src_a = 1'b1;
                  alu_op    = ALU_OP_W'(3'b001);
                  pc_src    = 2'd1;
                  pc_we     = zero;
               end
`ifdef MC_CTRL_BNE_EN
               OP_BNE: begin
                  alu_src_a = 1'b1;
                  alu_op    = ALU_OP_W'(3'b001);
                  pc_src    = 2'd1;
                  pc_we     = ~zero;
               end
`endif
               OP_JAL: begin
                  reg_we  = 1'b1;
                  reg_dst = 2'd2;
                  wb_sel  = 2'd2;
                  pc_we   = 1'b1;
                  pc_src  = 2'd2;
               end
               default: state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (op == OP_SW);
            if (timeout) begin
               mem_req   = 1'b0;
               mem_we    = 1'b0;
               bus_err   = 1'b1;
               state_nxt = S_FETCH;
            end else if (mem_ready) begin
               state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            reg_dst   = (op == OP_RTYPE) ? 2'd1 : 2'd0;
            wb_sel    = (op == OP_LW) ? 2'd1 : 2'd0;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (stall) begin
         state_nxt = state;
         pc_we     = 1'b0;
         ir_we     = 1'b0;
         reg_we    = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         illegal   = 1'b0;
      end
   end

   // Timeout counter: counts unanswered request cycles, clears on any move.
   always_comb begin
      to_cnt_nxt = to_cnt;
      if (stall) begin
         to_cnt_nxt = to_cnt;
      end else if ((state_nxt != state) || timeout) begin
         to_cnt_nxt = '0;
      end else if (mem_phase && !mem_ready && (to_cnt != TO_LIMIT)) begin
         to_cnt_nxt = to_cnt + CNT_W'(1);
      end
   end

   // State and timeout counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         to_cnt <= '0;
      end else begin
         state  <= state_nxt;
         to_cnt <= to_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (TIMEOUT_CYC = 4).
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero, stall, mem_ready;
   logic       mem_req, mem_we, iord, ir_we, pc_we;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_op;
   logic [2:0] alu_op;
   logic       reg_we;
   logic [1:0] reg_dst, wb_sel;
   logic       illegal, bus_err;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] got, exp;

   // clock / reset block
   always #5 clk = ~clk;

   multicycle_ctrl #(.ALU_OP_W(3), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .stall(stall),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .reg_we(reg_we),
      .reg_dst(reg_dst), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
      .state_o(state_o)
   );

   logic [23:0] all_out;
   assign all_out = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                     alu_src_b, ext_op, alu_op, reg_we, reg_dst, wb_sel,
                     illegal, bus_err, state_o};

   // Advance one clock; return 2 time units after the edge so inputs can be
   // driven and outputs sampled well away from the next edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = 6'd0; zero = 1'b0; stall = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      got = 32'(all_out); exp = 32'd0; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      step(); op = 6'b000000; mem_ready = 1'b1; #1;
      got = 32'({state_o, mem_req, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op});
      exp = 32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 3'd0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rtype_fetch: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'({state_o, alu_src_a, alu_src_b, ext_op, alu_op, illegal});
      exp = 32'({3'd2, 1'b0, 2'd3, 1'b1, 3'd0, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rtype_decode: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'({state_o, alu_src_a, alu_src_b, alu_op, reg_we});
      exp = 32'({3'd3, 1'b1, 2'd0, 3'b011, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rtype_exec: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'({state_o, reg_we, reg_dst, wb_sel});
      exp = 32'({3'd5, 1'b1, 2'd1, 2'd0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rtype_wb: got %h expected %h", got, exp); end
   endtask

   task automatic test_imm();
      logic [5:0] ops [4] = '{6'b001101, 6'b001110, 6'b001100, 6'b001000};
      logic [2:0] aops[4] = '{3'b010, 3'b100, 3'b101, 3'b110};
      logic       exts[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         step(); op = ops[i]; mem_ready = 1'b1; #1;
         got = 32'(state_o); exp = 32'd1; n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL imm%0d_fetch_state: got %h expected %h", i, got, exp); end
         step(); step(); #1;
         got = 32'({state_o, alu_src_a, alu_src_b, ext_op, alu_op});
         exp = 32'({3'd3, 1'b1, 2'd2, exts[i], aops[i]}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL imm%0d_exec: got %h expected %h", i, got, exp); end
         step(); #1;
         got = 32'({state_o, reg_we, reg_dst, wb_sel});
         exp = 32'({3'd5, 1'b1, 2'd0, 2'd0}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL imm%0d_wb: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_lw_wait();
      step(); op = 6'b100011; mem_ready = 1'b1; #1;
      step(); step(); #1;
      got = 32'({state_o, alu_src_a, alu_src_b, ext_op, alu_op});
      exp = 32'({3'd3, 1'b1, 2'd2, 1'b1, 3'd0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL lw_exec: got %h expected %h", got, exp); end
      for (int i = 0; i < 4; i++) begin
         step(); mem_ready = (i == 3); #1;
         got = 32'({state_o, mem_req, iord, mem_we, bus_err});
         exp = 32'({3'd4, 1'b1, 1'b1, 1'b0, 1'b0}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL lw_mem_cycle%0d: got %h expected %h", i, got, exp); end
      end
      step(); #1;
      got = 32'({state_o, reg_we, reg_dst, wb_sel});
      exp = 32'({3'd5, 1'b1, 2'd0, 2'd1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL lw_wb: got %h expected %h", got, exp); end
   endtask

   task automatic test_branch_jal();
      logic zs[2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         step(); op = 6'b000100; zero = zs[i]; mem_ready = 1'b1; #1;
         got = 32'(state_o); exp = 32'd1; n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL beq%0d_fetch_state: got %h expected %h", i, got, exp); end
         step(); step(); #1;
         got = 32'({state_o, alu_src_a, alu_src_b, alu_op, pc_src, pc_we});
         exp = 32'({3'd3, 1'b1, 2'd0, 3'b001, 2'd1, zs[i]}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL beq%0d_exec: got %h expected %h", i, got, exp); end
      end
      step(); op = 6'b000011; zero = 1'b0; #1;
      step(); step(); #1;
      got = 32'({state_o, reg_we, reg_dst, wb_sel, pc_we, pc_src});
      exp = 32'({3'd3, 1'b1, 2'd2, 2'd2, 1'b1, 2'd2}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL jal_exec: got %h expected %h", got, exp); end
   endtask

   task automatic test_illegal();
      step(); op = 6'b111111; mem_ready = 1'b1; #1;
      step(); #1;
      got = 32'({state_o, illegal}); exp = 32'({3'd2, 1'b1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL illegal_decode: got %h expected %h", got, exp); end
      step(); op = 6'b000101; zero = 1'b0; #1;
      got = 32'({state_o, illegal}); exp = 32'({3'd1, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL illegal_refetch: got %h expected %h", got, exp); end
      step(); #1;
`ifdef MC_CTRL_BNE_EN
      got = 32'({state_o, illegal}); exp = 32'({3'd2, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL bne_decode: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'({state_o, pc_we, pc_src}); exp = 32'({3'd3, 1'b1, 2'd1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL bne_exec: got %h expected %h", got, exp); end
`else
      got = 32'({state_o, illegal}); exp = 32'({3'd2, 1'b1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL bne_illegal_decode: got %h expected %h", got, exp); end
`endif
   endtask

   task automatic test_timeout();
      step(); op = 6'b000000; mem_ready = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin step(); #1; end
         got = 32'({state_o, mem_req, bus_err, ir_we});
         exp = 32'({3'd1, 1'b1, 1'b0, 1'b0}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL timeout_wait%0d: got %h expected %h", i, got, exp); end
      end
      step(); #1;
      got = 32'({state_o, mem_req, bus_err, ir_we, pc_we});
      exp = 32'({3'd1, 1'b0, 1'b1, 1'b0, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL timeout_fire: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'({state_o, mem_req, bus_err, ir_we});
      exp = 32'({3'd1, 1'b1, 1'b0, 1'b0}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL timeout_refetch: got %h expected %h", got, exp); end
      // Counter was cleared: 3 more empty cycles then a ready on the 5th
      // cycle, which coincides with the timeout and must win.
      for (int i = 0; i < 3; i++) step();
      step(); mem_ready = 1'b1; #1;
      got = 32'({state_o, mem_req, bus_err, ir_we, pc_we});
      exp = 32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL timeout_ready_wins: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'(state_o); exp = 32'd2; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL timeout_ready_decode: got %h expected %h", got, exp); end
      step(); step();
   endtask

   task automatic test_stall_sw_reset();
      step(); op = 6'b101011; mem_ready = 1'b1; #1;
      step(); step(); step(); stall = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) begin step(); #1; end
         got = 32'({state_o, mem_req, mem_we});
         exp = 32'({3'd4, 1'b0, 1'b0}); n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL sw_stall%0d: got %h expected %h", i, got, exp); end
      end
      step(); stall = 1'b0; #1;
      got = 32'({state_o, mem_req, mem_we, iord});
      exp = 32'({3'd4, 1'b1, 1'b1, 1'b1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL sw_write: got %h expected %h", got, exp); end
      step(); op = 6'b000000; #1;
      got = 32'(state_o); exp = 32'd1; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL sw_done_fetch: got %h expected %h", got, exp); end
      step(); step(); #1;
      got = 32'(state_o); exp = 32'd3; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL prereset_exec: got %h expected %h", got, exp); end
      rst_n = 1'b0; #1;
      got = 32'(all_out); exp = 32'd0; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL midreset_outputs: got %h expected %h", got, exp); end
      step(); #1;
      got = 32'(all_out); exp = 32'd0; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL midreset_held: got %h expected %h", got, exp); end
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      step(); op = 6'b000000; mem_ready = 1'b1; #1;
      got = 32'({state_o, ir_we, pc_we}); exp = 32'({3'd1, 1'b1, 1'b1}); n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL recover_fetch: got %h expected %h", got, exp); end
      step(); step(); step(); step(); #1;
      got = 32'(state_o); exp = 32'd1; n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL recover_next_fetch: got %h expected %h", got, exp); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_imm();
      test_lw_wait();
      test_branch_jal();
      test_illegal();
      test_timeout();
      test_stall_sw_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
